// File: rtl/apb_master_ctrl.sv
// APB master sequencer: takes single read/write requests, runs IDLE/SETUP/ACCESS
// towards one of two slaves and returns a one-cycle response (read data or timeout).
module apb_master_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W:0]   req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] padd,
    output logic [DATA_W-1:0] pwdata,
    input  logic              PREADY1,
    input  logic              PREADY2,
    input  logic [DATA_W-1:0] prdata1,
    input  logic [DATA_W-1:0] prdata2
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              psel1_q, psel1_d;
    logic              psel2_q, psel2_d;
    logic              penable_q, penable_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;

    // The unselected slave's handshake is never looked at.
    assign sel_ready = addr_q[ADDR_W] ? PREADY2 : PREADY1;
    assign sel_rdata = addr_q[ADDR_W] ? prdata2 : prdata1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        psel1_d     = psel1_q;
        psel2_d     = psel2_q;
        penable_d   = penable_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d   = SETUP;
                    wr_d      = req_write;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    psel1_d   = ~req_addr[ADDR_W];
                    psel2_d   = req_addr[ADDR_W];
                    penable_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (sel_ready) begin
                    state_d     = IDLE;
                    psel1_d     = 1'b0;
                    psel2_d     = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = wr_q ? '0 : sel_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    // Slave never answered: abandon the transfer with an error response.
                    state_d     = IDLE;
                    psel1_d     = 1'b0;
                    psel2_d     = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                psel1_d   = 1'b0;
                psel2_d   = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRST) begin
        if (!PRST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            psel1_q     <= psel1_d;
            psel2_q     <= psel2_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign PSEL1     = psel1_q;
    assign PSEL2     = psel2_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = wr_q;
    assign padd      = addr_q[ADDR_W-1:0];
    assign pwdata    = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed scenarios plus randomized transfers, each
// checked cycle by cycle against latencies derived from the wait-state count.
module tb_apb_master_ctrl;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int AW1     = ADDR_W + 1;

    logic              PCLK = 1'b0;
    logic              PRST;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W:0]   req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL1;
    logic              PSEL2;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] padd;
    logic [DATA_W-1:0] pwdata;
    logic              PREADY1;
    logic              PREADY2;
    logic [DATA_W-1:0] prdata1;
    logic [DATA_W-1:0] prdata2;

    int checks = 0;
    int errors = 0;

    apb_master_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK     (PCLK),
        .PRST     (PRST),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .PSEL1    (PSEL1),
        .PSEL2    (PSEL2),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .padd     (padd),
        .pwdata   (pwdata),
        .PREADY1  (PREADY1),
        .PREADY2  (PREADY2),
        .prdata1  (prdata1),
        .prdata2  (prdata2)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer: the selected slave holds PREADY low for w ACCESS cycles.
    // A transfer that is not answered within TIMEOUT ACCESS cycles ends in an error.
    task automatic run_txn(input logic wr, input logic [ADDR_W:0] addr,
                           input logic [DATA_W-1:0] wd, input int w, input bit fixed,
                           input logic [DATA_W-1:0] f1, input logic [DATA_W-1:0] f2);
        bit                to;
        int                n_acc;
        int                last;
        logic              sel;
        logic              rdy;
        bit                in_xfer;
        bit                in_acc;
        logic [DATA_W-1:0] exp_rd;
        to     = (w >= TIMEOUT);
        n_acc  = to ? TIMEOUT : w + 1;
        last   = 2 + n_acc;
        sel    = addr[ADDR_W];
        exp_rd = '0;
        @(negedge PCLK);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        PREADY1   = 1'b0;
        PREADY2   = 1'b0;
        check("accept_req_ready", 32'(req_ready), 32'd1);
        @(negedge PCLK);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = AW1'($urandom);
        req_wdata = DATA_W'($urandom);
        for (int j = 1; j <= last; j++) begin
            in_xfer = (j < last);
            in_acc  = (j >= 2) && (j < last);
            check("psel_selected", 32'(sel ? PSEL2 : PSEL1), 32'(in_xfer));
            check("psel_other", 32'(sel ? PSEL1 : PSEL2), 32'd0);
            check("penable", 32'(PENABLE), 32'(in_acc));
            check("req_ready", 32'(req_ready), 32'(!in_xfer));
            check("rsp_valid", 32'(rsp_valid), 32'(j == last));
            if (in_xfer) begin
                check("padd", 32'(padd), 32'(addr[ADDR_W-1:0]));
                check("pwdata", 32'(pwdata), 32'(wd));
                check("pwrite", 32'(PWRITE), 32'(wr));
            end else begin
                check("rsp_err", 32'(rsp_err), 32'(to));
                check("rsp_rdata", 32'(rsp_rdata), (to || wr) ? 32'd0 : 32'(exp_rd));
            end
            if (j < last) begin
                prdata1 = fixed ? f1 : DATA_W'($urandom);
                prdata2 = fixed ? f2 : DATA_W'($urandom);
                rdy     = in_acc ? ((j - 2) >= w) : 1'($urandom);
                if (sel) begin
                    PREADY2 = rdy;
                    PREADY1 = 1'($urandom);
                end else begin
                    PREADY1 = rdy;
                    PREADY2 = 1'($urandom);
                end
                if (in_acc && rdy) exp_rd = sel ? prdata2 : prdata1;
                @(negedge PCLK);
            end
        end
        PREADY1 = 1'b0;
        PREADY2 = 1'b0;
    endtask

    initial begin
        PRST      = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        PREADY1   = 1'b0;
        PREADY2   = 1'b0;
        prdata1   = '0;
        prdata2   = '0;

        // Reset state
        repeat (2) @(negedge PCLK);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_psel1", 32'(PSEL1), 32'd0);
        check("rst_psel2", 32'(PSEL2), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_pwrite", 32'(PWRITE), 32'd0);
        check("rst_padd", 32'(padd), 32'd0);
        check("rst_pwdata", 32'(pwdata), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        PRST = 1'b1;

        // Write slave1, zero wait states
        run_txn(1'b1, 9'h005, 8'hA5, 0, 1'b0, 8'h00, 8'h00);
        // Read slave2 with a distinct value on the unselected slave
        run_txn(1'b0, 9'h10A, 8'h00, 0, 1'b1, 8'hFF, 8'h3C);
        check("read_slave2_data_latched", 32'(rsp_rdata), 32'h3C);
        // Three wait states on slave1
        run_txn(1'b1, 9'h033, 8'h5A, 3, 1'b0, 8'h00, 8'h00);
        // Slave2 never ready: timeout
        run_txn(1'b0, 9'h1F0, 8'h00, 1000, 1'b0, 8'h00, 8'h00);
        check("timeout_back_idle", 32'(req_ready), 32'd1);
        // Slowest transfer that still completes without error
        run_txn(1'b0, 9'h044, 8'h00, TIMEOUT - 1, 1'b0, 8'h00, 8'h00);

        // Back-to-back: request held valid across two transfers
        @(negedge PCLK);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 9'h001;
        req_wdata = 8'h11;
        PREADY1   = 1'b1;
        PREADY2   = 1'b1;
        check("b2b_ready_t0", 32'(req_ready), 32'd1);
        @(negedge PCLK);
        req_addr  = 9'h102;
        req_wdata = 8'h22;
        check("b2b_setup1_psel1", 32'(PSEL1), 32'd1);
        check("b2b_setup1_psel2", 32'(PSEL2), 32'd0);
        check("b2b_setup1_ready", 32'(req_ready), 32'd0);
        @(negedge PCLK);
        check("b2b_access1_penable", 32'(PENABLE), 32'd1);
        check("b2b_access1_ready", 32'(req_ready), 32'd0);
        check("b2b_access1_padd", 32'(padd), 32'h01);
        check("b2b_access1_pwdata", 32'(pwdata), 32'h11);
        @(negedge PCLK);
        check("b2b_rsp1_valid", 32'(rsp_valid), 32'd1);
        check("b2b_rsp1_ready", 32'(req_ready), 32'd1);
        check("b2b_rsp1_psel1", 32'(PSEL1), 32'd0);
        @(negedge PCLK);
        req_valid = 1'b0;
        check("b2b_setup2_psel2", 32'(PSEL2), 32'd1);
        check("b2b_setup2_psel1", 32'(PSEL1), 32'd0);
        check("b2b_setup2_penable", 32'(PENABLE), 32'd0);
        check("b2b_setup2_padd", 32'(padd), 32'h02);
        check("b2b_setup2_pwdata", 32'(pwdata), 32'h22);
        @(negedge PCLK);
        check("b2b_access2_penable", 32'(PENABLE), 32'd1);
        @(negedge PCLK);
        check("b2b_rsp2_valid", 32'(rsp_valid), 32'd1);
        check("b2b_rsp2_err", 32'(rsp_err), 32'd0);
        PREADY1 = 1'b0;
        PREADY2 = 1'b0;

        // Reset in the middle of ACCESS
        @(negedge PCLK);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 9'h077;
        @(negedge PCLK);
        req_valid = 1'b0;
        @(negedge PCLK);
        check("mid_access_penable", 32'(PENABLE), 32'd1);
        #2 PRST = 1'b0;
        #1;
        check("mid_rst_psel1", 32'(PSEL1), 32'd0);
        check("mid_rst_psel2", 32'(PSEL2), 32'd0);
        check("mid_rst_penable", 32'(PENABLE), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        PREADY1 = 1'b1;
        repeat (2) begin
            @(negedge PCLK);
            check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        PREADY1 = 1'b0;
        PRST    = 1'b1;
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        run_txn(1'b0, 9'h012, 8'h00, 1, 1'b0, 8'h00, 8'h00);

        // Randomized transfers
        for (int n = 0; n < 40; n++) begin
            int w;
            w = ($urandom_range(0, 7) == 0) ? TIMEOUT + int'($urandom_range(0, 3))
                                             : int'($urandom_range(0, 4));
            repeat ($urandom_range(0, 2)) @(negedge PCLK);
            run_txn(1'($urandom), AW1'($urandom), DATA_W'($urandom), w, 1'b0, 8'h00, 8'h00);
        end

        @(negedge PCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
APB master sequencer for the two-slave APB subsystem. Accepts single read/write requests on a valid/ready request port and runs the APB IDLE/SETUP/ACCESS protocol. Decodes the request address to one of two slave selects, multiplexes each slave's PREADY/PRDATA back, and returns a one-cycle response with read data or a timeout error. Sits between the system-side requester and slave1/slave2.

Parameters:
ADDR_W, 8, APB address width (padd); request address is ADDR_W+1 bits, MSB = slave select
DATA_W, 8, APB data width
TIMEOUT, 16, max ACCESS cycles waiting for PREADY before error (>=1)

Ports:
PCLK  in  1  APB clock, all logic rising-edge
PRST  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept request
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W+1  bit ADDR_W: 0=slave1, 1=slave2; low bits -> padd
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  DATA_W  read data (0 for writes/errors)
rsp_err  out  1  timeout flag, valid with rsp_valid
PSEL1  out  1  slave1 select
PSEL2  out  1  slave2 select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
padd  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
PREADY1  in  1  slave1 ready
PREADY2  in  1  slave2 ready
prdata1  in  DATA_W  slave1 read data
prdata2  in  DATA_W  slave2 read data

Behaviour:
- Reset (PRST=0, async): state=IDLE; all outputs 0 except req_ready=1; timeout counter=0.
- All APB outputs and rsp_* are registered; req_ready = (state==IDLE) & !PRST-release-glitch (pure state decode).
- IDLE: req_ready=1, PSELx=0, PENABLE=0. On req_valid&req_ready at edge T: latch write/addr/wdata; next state SETUP.
- SETUP (cycle T+1): PSEL1 or PSEL2 =1 per latched addr MSB (never both), PENABLE=0, PWRITE/padd/pwdata driven from latched values; unconditional -> ACCESS.
- ACCESS (T+2 onward): PENABLE=1, PSELx, PWRITE, padd, pwdata held stable. Selected ready = MSB ? PREADY2 : PREADY1; unselected slave's PREADY/prdata ignored.
  - Selected ready=1: rsp_valid=1 next cycle, rsp_err=0, rsp_rdata = read ? selected prdata sampled at that edge : 0; PSELx/PENABLE drop to 0; -> IDLE.
  - Selected ready=0: counter++; when counter reaches TIMEOUT-1 with ready still 0: rsp_valid=1, rsp_err=1, rsp_rdata=0; -> IDLE.
  - Counter cleared on every SETUP entry.
- Zero-wait-state latency: accept at T, rsp_valid at T+3; req_ready high again at T+3 (rsp cycle is IDLE), so back-to-back requests yield one transfer per 3 cycles.
- rsp_valid is a single-cycle pulse; no backpressure on response.
- req_valid while not IDLE is ignored (req_ready=0); requester must hold request.
- PRST asserted mid-transfer: immediate return to IDLE, PSELx/PENABLE=0, no rsp_valid pulse for the aborted transfer.
- padd = req_addr[ADDR_W-1:0], no translation; writes to addresses beyond slave depth are passed through unchanged.

Test Plan:
- Write slave1: req addr=0x005, wdata=0xA5, slave PREADY in ACCESS -> PSEL1=1 T+1, PENABLE=1 T+2, rsp_valid T+3 rsp_err=0 rsp_rdata=0x00, PSEL2 never high.
- Read slave2: addr=0x10A, prdata2=0x3C, prdata1=0xFF -> PSEL2 only, rsp_rdata=0x3C at T+3.
- Wait states: slave1 PREADY held low 3 ACCESS cycles -> PENABLE high 4 cycles, padd/pwdata stable throughout, rsp_valid at T+6.
- Timeout: TIMEOUT=16, PREADY2 stuck 0 -> exactly 16 ACCESS cycles, rsp_valid with rsp_err=1, rsp_rdata=0, back to IDLE.
- Back-to-back: req_valid held high for writes to 0x001 then 0x102 -> second SETUP exactly 3 cycles after first, req_ready low during SETUP/ACCESS.
- Reset mid-ACCESS: drop PRST during ACCESS -> PSELx/PENABLE=0 asynchronously, no rsp_valid; after release req_ready=1 and new read completes normally.
